word_count_accum: RTL

WORD_COUNT_ACCUM -- requirements
Module: word_count_accum

---
 rtl/word_count_accum.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/word_count_accum.sv
// Word-count accumulator: a DEPTH-entry {value, count} table updated by a one-per-cycle
// read-modify-write pipeline, with a table clear walk and a ready/valid dump of nonzero entries.
module word_count_accum #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       accum_addr,
  input  logic [63:0]       accum_din,
  input  logic              accum_we,
  input  logic              clear_kick,
  input  logic              dump_kick,
  output logic              busy,
  output logic              drop_err,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_value,
  output logic [31:0]       out_count,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              dump_done
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    StClear,
    StIdle,
    StDumpRd,
    StDumpEval,
    StDumpOut
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   idx_q;
  logic                dump_wait_q;

  // Table storage, synchronous read with read-before-write behaviour.
  logic [63:0]         mem [DEPTH];
  logic [63:0]         rd_data_q;
  logic                ram_re;
  logic [ADDR_W-1:0]   ram_raddr;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_waddr;
  logic [63:0]         ram_wdata;

  // Update waiting for its read data (second half of read-modify-write).
  logic                pend_valid_q;
  logic [ADDR_W-1:0]   pend_addr_q;
  logic [31:0]         pend_value_q;
  logic [31:0]         pend_inc_q;

  // Copy of the previous write; the RAM read issued alongside it returned stale data.
  logic                fwd_valid_q;
  logic [ADDR_W-1:0]   fwd_addr_q;
  logic [31:0]         fwd_count_q;

  logic                drop_err_q;
  logic [ADDR_W-1:0]   out_addr_q;
  logic [31:0]         out_value_q;
  logic [31:0]         out_count_q;
  logic                out_valid_q;
  logic                dump_done_q;

  logic                upd_accept;
  logic [31:0]         old_count;
  logic [32:0]         sum;
  logic [31:0]         new_count;
  logic                idx_last;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^accum_addr[31:ADDR_W];

  assign upd_accept = (state_q == StIdle) && accum_we;
  assign idx_last   = &idx_q;

  always_comb begin
    old_count = rd_data_q[31:0];
    if (fwd_valid_q && (fwd_addr_q == pend_addr_q)) begin
      old_count = fwd_count_q;
    end
    sum       = {1'b0, old_count} + {1'b0, pend_inc_q};
    new_count = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  end

  always_comb begin
    ram_re    = 1'b0;
    ram_raddr = idx_q;
    if (upd_accept) begin
      ram_re    = 1'b1;
      ram_raddr = accum_addr[ADDR_W-1:0];
    end else if ((state_q == StDumpRd) && !dump_wait_q) begin
      ram_re    = 1'b1;
      ram_raddr = idx_q;
    end
  end

  // Reset discards an in-flight update, so no write lands during it.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = pend_addr_q;
    ram_wdata = {pend_value_q, new_count};
    if (!reset) begin
      if (state_q == StClear) begin
        ram_we    = 1'b1;
        ram_waddr = idx_q;
        ram_wdata = 64'd0;
      end else if (pend_valid_q) begin
        ram_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_waddr] <= ram_wdata;
    end
    if (ram_re) begin
      rd_data_q <= mem[ram_raddr];
    end
  end

  always_ff @(posedge clk) begin
    pend_addr_q  <= accum_addr[ADDR_W-1:0];
    pend_value_q <= accum_din[63:32];
    pend_inc_q   <= accum_din[31:0];
    fwd_addr_q   <= pend_addr_q;
    fwd_count_q  <= new_count;
    if (reset) begin
      state_q      <= StClear;
      idx_q        <= '0;
      dump_wait_q  <= 1'b0;
      pend_valid_q <= 1'b0;
      fwd_valid_q  <= 1'b0;
      drop_err_q   <= 1'b0;
      out_addr_q   <= '0;
      out_value_q  <= '0;
      out_count_q  <= '0;
      out_valid_q  <= 1'b0;
      dump_done_q  <= 1'b0;
    end else begin
      dump_done_q  <= 1'b0;
      // An update in the same cycle as a clear kick is wiped by the clear anyway.
      pend_valid_q <= upd_accept && !clear_kick;
      fwd_valid_q  <= pend_valid_q;
      if (accum_we && (state_q != StIdle)) begin
        drop_err_q <= 1'b1;
      end
      unique case (state_q)
        StClear: begin
          idx_q <= idx_q + 1'b1;
          if (idx_last) begin
            state_q <= StIdle;
          end
        end
        StIdle: begin
          if (clear_kick) begin
            state_q <= StClear;
            idx_q   <= '0;
          end else if (dump_kick) begin
            state_q     <= StDumpRd;
            idx_q       <= '0;
            dump_wait_q <= 1'b1;
          end
        end
        StDumpRd: begin
          // First pass lets the last accepted update retire before reading.
          if (dump_wait_q) begin
            dump_wait_q <= 1'b0;
          end else begin
            state_q <= StDumpEval;
          end
        end
        StDumpEval: begin
          if (rd_data_q[31:0] != 32'd0) begin
            out_addr_q  <= idx_q;
            out_value_q <= rd_data_q[63:32];
            out_count_q <= rd_data_q[31:0];
            out_valid_q <= 1'b1;
            state_q     <= StDumpOut;
          end else if (idx_last) begin
            dump_done_q <= 1'b1;
            state_q     <= StIdle;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= StDumpRd;
          end
        end
        StDumpOut: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (idx_last) begin
              dump_done_q <= 1'b1;
              state_q     <= StIdle;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= StDumpRd;
            end
          end
        end
        default: begin
          state_q <= StClear;
          idx_q   <= '0;
        end
      endcase
    end
  end

  assign busy      = (state_q != StIdle);
  assign drop_err  = drop_err_q;
  assign out_addr  = out_addr_q;
  assign out_value = out_value_q;
  assign out_count = out_count_q;
  assign out_valid = out_valid_q;
  assign dump_done = dump_done_q;

endmodule
